// File: rtl/ula_pkg.sv
// Shared definitions for the ula_arbitro slice: ALU select codes, FSM states, default data width.
package ula_pkg;

    localparam int ULA_DATA_W = 32;

    localparam logic [2:0] ULA_MOV = 3'b000;
    localparam logic [2:0] ULA_ADD = 3'b001;
    localparam logic [2:0] ULA_SUB = 3'b010;
    localparam logic [2:0] ULA_AND = 3'b011;
    localparam logic [2:0] ULA_OR  = 3'b100;
    localparam logic [2:0] ULA_SHL = 3'b101;
    localparam logic [2:0] ULA_SHR = 3'b110;
    localparam logic [2:0] ULA_NOT = 3'b111;

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        EXECUTA  = 2'b01,
        RESPONDE = 2'b10
    } ula_estado_t;

endpackage

// File: rtl/ula_arb_rr.sv
// Combinational winner pick: first valid requester scanning upward from ptr with wrap-around.
module ula_arb_rr #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    index,
    output logic               any
);

    int   cand_s;
    logic hit_s;

    // Walk offsets 0..NUM_REQ-1 from ptr; the first valid candidate wins.
    always_comb begin
        grant  = '0;
        index  = '0;
        any    = 1'b0;
        cand_s = 0;
        hit_s  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = (int'(ptr) + i >= NUM_REQ) ? (int'(ptr) + i - NUM_REQ) : (int'(ptr) + i);
            for (int j = 0; j < NUM_REQ; j++) begin
                hit_s    = valid[j] & ~any & (cand_s == j);
                grant[j] = grant[j] | hit_s;
                index    = hit_s ? ID_W'(j) : index;
                any      = any | hit_s;
            end
        end
    end

endmodule

// File: rtl/ula_arbitro.sv
// Round-robin sequencer sharing one ALU among NUM_REQ requesters.
// Define ULA_ARB_PRIO_FIXA_EN for fixed priority (lowest index wins, no rr pointer).
module ula_arbitro
    import ula_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = ULA_DATA_W,
    parameter int ID_W    = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [3*NUM_REQ-1:0]      req_selecao,
    input  logic [DATA_W*NUM_REQ-1:0] req_x,
    input  logic [DATA_W*NUM_REQ-1:0] req_y,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_resultado,
    output logic                      resp_flag_n,
    output logic                      resp_flag_z
);

    ula_estado_t         state_r;
    logic [ID_W-1:0]     ptr_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_W-1:0]     win_idx_s;
    logic                win_any_s;
    logic [2:0]          sel_win_s;
    logic [DATA_W-1:0]   x_win_s;
    logic [DATA_W-1:0]   y_win_s;
    logic [2:0]          sel_r;
    logic [DATA_W-1:0]   x_r;
    logic [DATA_W-1:0]   y_r;
    logic [ID_W-1:0]     id_r;
    logic [DATA_W-1:0]   alu_s;
    logic                resp_valid_r;
    logic [ID_W-1:0]     resp_id_r;
    logic [DATA_W-1:0]   resp_resultado_r;
    logic                resp_flag_n_r;
    logic                resp_flag_z_r;
    logic                resp_hs_s;

    ula_arb_rr #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .valid (req_valid),
        .ptr   (ptr_s),
        .grant (grant_s),
        .index (win_idx_s),
        .any   (win_any_s)
    );

    assign resp_hs_s = (state_r == RESPONDE) & resp_ready;
    // Grants are only offered while idle and out of reset.
    assign req_ready = grant_s & {NUM_REQ{reset_n & (state_r == OCIOSO)}};

`ifdef ULA_ARB_PRIO_FIXA_EN
    assign ptr_s = '0;
`else
    logic [ID_W-1:0] rr_ptr_r;

    // Round-robin pointer moves past the owner once its response is consumed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r <= '0;
        end else if (resp_hs_s) begin
            rr_ptr_r <= (id_r == ID_W'(NUM_REQ - 1)) ? '0 : id_r + ID_W'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign ptr_s = rr_ptr_r;
`endif

    // One-hot grant steers the winner's operation onto the latch inputs.
    always_comb begin
        sel_win_s = '0;
        x_win_s   = '0;
        y_win_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_win_s = sel_win_s | ({3{grant_s[i]}} & req_selecao[3*i +: 3]);
            x_win_s   = x_win_s | ({DATA_W{grant_s[i]}} & req_x[DATA_W*i +: DATA_W]);
            y_win_s   = y_win_s | ({DATA_W{grant_s[i]}} & req_y[DATA_W*i +: DATA_W]);
        end
    end

    // Shared ALU, evaluated from the latched operands.
    always_comb begin
        alu_s = '0;
        case (sel_r)
            ULA_MOV: alu_s = x_r;
            ULA_ADD: alu_s = x_r + y_r;
            ULA_SUB: alu_s = x_r - y_r;
            ULA_AND: alu_s = x_r & y_r;
            ULA_OR:  alu_s = x_r | y_r;
            ULA_SHL: alu_s = (y_r >= DATA_W'(DATA_W)) ? '0 : (x_r << y_r);
            ULA_SHR: alu_s = (y_r >= DATA_W'(DATA_W)) ? '0 : (x_r >> y_r);
            ULA_NOT: alu_s = ~x_r;
            default: alu_s = '0;
        endcase
    end

    // Sequencer: accept in OCIOSO, register the ALU in EXECUTA, hold the response in RESPONDE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= OCIOSO;
            sel_r            <= '0;
            x_r              <= '0;
            y_r              <= '0;
            id_r             <= '0;
            resp_valid_r     <= 1'b0;
            resp_id_r        <= '0;
            resp_resultado_r <= '0;
            resp_flag_n_r    <= 1'b0;
            resp_flag_z_r    <= 1'b0;
        end else begin
            case (state_r)
                OCIOSO: begin
                    if (win_any_s) begin
                        sel_r   <= sel_win_s;
                        x_r     <= x_win_s;
                        y_r     <= y_win_s;
                        id_r    <= win_idx_s;
                        state_r <= EXECUTA;
                    end else begin
                        state_r <= OCIOSO;
                    end
                end
                EXECUTA: begin
                    resp_resultado_r <= alu_s;
                    resp_flag_n_r    <= alu_s[DATA_W-1];
                    resp_flag_z_r    <= (alu_s == '0);
                    resp_id_r        <= id_r;
                    resp_valid_r     <= 1'b1;
                    state_r          <= RESPONDE;
                end
                RESPONDE: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= OCIOSO;
                    end else begin
                        state_r      <= RESPONDE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= OCIOSO;
                end
            endcase
        end
    end

    assign resp_valid     = resp_valid_r;
    assign resp_id        = resp_id_r;
    assign resp_resultado = resp_resultado_r;
    assign resp_flag_n    = resp_flag_n_r;
    assign resp_flag_z    = resp_flag_z_r;

endmodule
